// File: rtl/instr_encoder_if.sv
// Request and write-back bus between a micro-op source and the instruction encoder.
// The request side, memory-write side and status signals travel together so the
// encoder has a single bus port.
interface instr_encoder_if #(
    parameter int DEPTH = 64
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_kind;
    logic [2:0]    in_alu;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [12:0]   in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_addr;
    logic [CW-1:0] count;
    logic          full;
    logic          err_illegal;

    // Request source and memory sink
    modport master (
        output clear, in_valid, in_kind, in_alu, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, count, full, err_illegal
    );

    // Encoder
    modport slave (
        input  clear, in_valid, in_kind, in_alu, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, count, full, err_illegal
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded micro-op requests into 32-bit words and
// streams them with an incrementing byte address toward instruction memory.
//
// state   | meaning
// EMPTY   | out_valid = 0, full = 0; ready for a request
// PENDING | out_valid = 1; word waiting for memory to take it
// FULL    | full = 1; no further requests until clear/reset, last word still drains
//
// The state is implied by out_valid_q and count_q rather than stored separately.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_encoder_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] K_LW   = 3'b000;
    localparam logic [2:0] K_SW   = 3'b001;
    localparam logic [2:0] K_BEQ  = 3'b010;
    localparam logic [2:0] K_RALU = 3'b011;
    localparam logic [2:0] K_IALU = 3'b100;

    localparam logic [2:0] A_ADD = 3'b000;
    localparam logic [2:0] A_SUB = 3'b001;
    localparam logic [2:0] A_SLT = 3'b101;
    localparam logic [2:0] A_OR  = 3'b011;
    localparam logic [2:0] A_AND = 3'b010;

    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_instr_q, out_instr_d;
    logic [31:0]   out_addr_q,  out_addr_d;
    logic [CW-1:0] count_q,     count_d;
    logic          err_q,       err_d;

    logic          full;
    logic          in_ready;
    logic          accept;
    logic [2:0]    funct3;
    logic          alu_ok;
    logic [31:0]   enc_word;
    logic          enc_legal;
    logic [12:0]   imm;

    assign imm      = bus.in_imm;
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full && (!out_valid_q || bus.out_ready) && !bus.clear;
    assign accept   = bus.in_valid && in_ready;

    // Combinational encode of the request currently on the bus, with legality flag
    always_comb begin
        funct3    = 3'b000;
        alu_ok    = 1'b1;
        enc_word  = '0;
        enc_legal = 1'b0;
        case (bus.in_alu)
            A_ADD:   funct3 = 3'b000;
            A_SUB:   funct3 = 3'b000;
            A_SLT:   funct3 = 3'b010;
            A_OR:    funct3 = 3'b110;
            A_AND:   funct3 = 3'b111;
            default: alu_ok = 1'b0;
        endcase
        case (bus.in_kind)
            K_LW: begin
                enc_word  = {imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, 7'b0000011};
                enc_legal = 1'b1;
            end
            K_SW: begin
                enc_word  = {imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010, imm[4:0], 7'b0100011};
                enc_legal = 1'b1;
            end
            K_BEQ: begin
                enc_word  = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, 3'b000,
                             imm[4:1], imm[11], 7'b1100011};
                enc_legal = 1'b1;
            end
            K_RALU: begin
                enc_word  = {(bus.in_alu == A_SUB) ? 7'b0100000 : 7'b0000000,
                             bus.in_rs2, bus.in_rs1, funct3, bus.in_rd, 7'b0110011};
                enc_legal = alu_ok;
            end
            K_IALU: begin
                // There is no subi in RV32I; sub on the immediate path is rejected.
                enc_word  = {imm[11:0], bus.in_rs1, funct3, bus.in_rd, 7'b0010011};
                enc_legal = alu_ok && (bus.in_alu != A_SUB);
            end
            default: begin
                enc_word  = '0;
                enc_legal = 1'b0;
            end
        endcase
    end

    // Next-state for the output register, counter and error pulse
    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        count_d     = count_q;
        err_d       = 1'b0;
        if (bus.clear) begin
            out_valid_d = 1'b0;
            out_instr_d = '0;
            out_addr_d  = BASE_ADDR;
            count_d     = '0;
        end else begin
            err_d = accept && !enc_legal;
            if (accept && enc_legal) begin
                out_valid_d = 1'b1;
                out_instr_d = enc_word;
                out_addr_d  = BASE_ADDR + (32'(count_q) << 2);
                count_d     = count_q + CW'(1);
            end else if (bus.out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= BASE_ADDR;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = out_instr_q;
    assign bus.out_addr    = out_addr_q;
    assign bus.count       = count_q;
    assign bus.full        = full;
    assign bus.err_illegal = err_q;
endmodule
